// File: rtl/mano_pkg.sv
// Shared definitions for the parametrised Mano core: opcodes,
// register-reference masks, sequence-counter states, ALU operations
// and the parameter legality check.
package mano_pkg;

    // Smallest word that still holds I + 3-bit opcode + 12 register-reference bits.
    localparam int MIN_DATA_W  = 16;
    // I bit plus 3 opcode bits sit above the address field.
    localparam int ADDR_MARGIN = 4;

    // Memory-reference opcodes; 7 selects the register-reference group.
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    // Register-reference operations, one bit each in IR[11:0].
    localparam logic [11:0] RR_CLA = 12'h800;
    localparam logic [11:0] RR_CLE = 12'h400;
    localparam logic [11:0] RR_CMA = 12'h200;
    localparam logic [11:0] RR_CME = 12'h100;
    localparam logic [11:0] RR_CIR = 12'h080;
    localparam logic [11:0] RR_CIL = 12'h040;
    localparam logic [11:0] RR_INC = 12'h020;
    localparam logic [11:0] RR_SPA = 12'h010;
    localparam logic [11:0] RR_SNA = 12'h008;
    localparam logic [11:0] RR_SZA = 12'h004;
    localparam logic [11:0] RR_SZE = 12'h002;
    localparam logic [11:0] RR_HLT = 12'h001;

    // Sequence counter timing states.
    typedef enum logic [2:0] {
        T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
        T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
    } sc_e;

    // Operations the ALU applies to {E,AC}; ALU_NOP passes both through.
    typedef enum logic [3:0] {
        ALU_NOP, ALU_AND, ALU_ADD, ALU_LDA, ALU_CLA, ALU_CLE,
        ALU_CMA, ALU_CME, ALU_CIR, ALU_CIL, ALU_INC
    } alu_op_e;

    // True when the requested widths can hold the instruction format.
    function automatic bit params_ok(input int data_w, input int addr_w);
        return (data_w >= MIN_DATA_W) && (addr_w <= data_w - ADDR_MARGIN);
    endfunction

    // True when the register-reference field has the given operation bit set.
    function automatic logic rr_has(input logic [11:0] rr, input logic [11:0] mask);
        return |(rr & mask);
    endfunction

endpackage

// File: rtl/mano_alu.sv
// Combinational accumulator datapath: produces the next {E,AC} for
// the memory-reference arithmetic and the register-reference AC/E ops.
module mano_alu
    import mano_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] dr,
    input  logic              e,
    output logic [DATA_W-1:0] ac_next,
    output logic              e_next
);

    // Next accumulator/extend value; E only moves on ADD, CLE, CME, CIR, CIL.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ac_next = ac;
        e_next  = e;
        case (op)
            ALU_AND: ac_next = ac & dr;
            ALU_ADD: {e_next, ac_next} = {1'b0, ac} + {1'b0, dr};
            ALU_LDA: ac_next = dr;
            ALU_CLA: ac_next = '0;
            ALU_CLE: e_next  = 1'b0;
            ALU_CMA: ac_next = ~ac;
            ALU_CME: e_next  = ~e;
            ALU_CIR: begin
                ac_next = {e, ac[DATA_W-1:1]};
                e_next  = ac[0];
            end
            ALU_CIL: begin
                ac_next = {ac[DATA_W-2:0], e};
                e_next  = ac[DATA_W-1];
            end
            ALU_INC: ac_next = ac + DATA_W'(1);
            default: ;
        endcase
    end

endmodule

// File: rtl/mano_core_param.sv
// Parametrised Mano basic computer core. The sequence counter steps
// T0..T6 and stalls on every memory access until mem_ack.
module mano_core_param
    import mano_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] AR,
    output logic [DATA_W-1:0] AC,
    output logic [DATA_W-1:0] DR,
    output logic [DATA_W-1:0] IR,
    output logic              E,
    output logic [2:0]        SC
);

    if (!params_ok(DATA_W, ADDR_W)) begin : g_param_check
        $error("mano_core_param: need DATA_W >= 16 and ADDR_W <= DATA_W-4");
    end

    logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
    logic [DATA_W-1:0] ac_q, ac_d, dr_q, dr_d, ir_q, ir_d;
    logic              e_q, e_d, ind_q, ind_d, halted_q, halted_d;
    sc_e               sc_q, sc_d;

    logic [2:0]        opcode;
    logic [11:0]       rr;
    logic              reg_ref;
    logic              done;
    logic              skip;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_ac;
    logic              alu_e;

    assign opcode  = ir_q[DATA_W-2:DATA_W-4];
    assign rr      = ir_q[11:0];
    assign reg_ref = (opcode == OP_REG);
    assign done    = mem_req && mem_ack;

    // Select the ALU operation for the current timing state.
    always_comb begin
        alu_op = ALU_NOP;
        if (!halted_q) begin
            if (sc_q == T5) begin
                case (opcode)
                    OP_AND:  alu_op = ALU_AND;
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_LDA:  alu_op = ALU_LDA;
                    default: ;
                endcase
            end else if (sc_q == T3 && reg_ref && !ind_q) begin
                if      (rr_has(rr, RR_CLA)) alu_op = ALU_CLA;
                else if (rr_has(rr, RR_CLE)) alu_op = ALU_CLE;
                else if (rr_has(rr, RR_CMA)) alu_op = ALU_CMA;
                else if (rr_has(rr, RR_CME)) alu_op = ALU_CME;
                else if (rr_has(rr, RR_CIR)) alu_op = ALU_CIR;
                else if (rr_has(rr, RR_CIL)) alu_op = ALU_CIL;
                else if (rr_has(rr, RR_INC)) alu_op = ALU_INC;
            end
        end
    end

    mano_alu #(.DATA_W(DATA_W)) u_alu (
        .op      (alu_op),
        .ac      (ac_q),
        .dr      (dr_q),
        .e       (e_q),
        .ac_next (alu_ac),
        .e_next  (alu_e)
    );

    // Memory request outputs, decoded from registered state only so they hold until ack.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (!halted_q) begin
            case (sc_q)
                T1: mem_req = 1'b1;
                T3: mem_req = !reg_ref && ind_q;
                T4: begin
                    case (opcode)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: mem_req = 1'b1;
                        OP_STA: begin
                            mem_req   = 1'b1;
                            mem_we    = 1'b1;
                            mem_wdata = ac_q;
                        end
                        OP_BSA: begin
                            mem_req   = 1'b1;
                            mem_we    = 1'b1;
                            mem_wdata = DATA_W'(pc_q);
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    mem_req   = (opcode == OP_ISZ);
                    mem_we    = (opcode == OP_ISZ);
                    mem_wdata = dr_q;
                end
                default: ;
            endcase
        end
    end

    // Next-state and register-transfer decode; access states advance only on ack.
    always_comb begin
        pc_d     = pc_q;
        ar_d     = ar_q;
        dr_d     = dr_q;
        ir_d     = ir_q;
        ind_d    = ind_q;
        halted_d = halted_q;
        sc_d     = sc_q;
        ac_d     = alu_ac;
        e_d      = alu_e;
        skip     = 1'b0;
        if (!halted_q) begin
            case (sc_q)
                T0: begin
                    ar_d = pc_q;
                    sc_d = T1;
                end
                T1: if (done) begin
                    ir_d = mem_rdata;
                    pc_d = pc_q + ADDR_W'(1);
                    sc_d = T2;
                end
                T2: begin
                    ar_d  = ir_q[ADDR_W-1:0];
                    ind_d = ir_q[DATA_W-1];
                    sc_d  = T3;
                end
                T3: begin
                    if (reg_ref) begin
                        if (!ind_q) begin
                            skip = (rr_has(rr, RR_SPA) && !ac_q[DATA_W-1]) ||
                                   (rr_has(rr, RR_SNA) &&  ac_q[DATA_W-1]) ||
                                   (rr_has(rr, RR_SZA) && (ac_q == '0))    ||
                                   (rr_has(rr, RR_SZE) && !e_q);
                            if (skip) pc_d = pc_q + ADDR_W'(1);
                            if (rr_has(rr, RR_HLT)) halted_d = 1'b1;
                        end
                        sc_d = T0;
                    end else if (ind_q) begin
                        if (done) begin
                            ar_d = mem_rdata[ADDR_W-1:0];
                            sc_d = T4;
                        end
                    end else begin
                        sc_d = T4;
                    end
                end
                T4: begin
                    case (opcode)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: if (done) begin
                            dr_d = mem_rdata;
                            sc_d = T5;
                        end
                        OP_STA: if (done) sc_d = T0;
                        OP_BUN: begin
                            pc_d = ar_q;
                            sc_d = T0;
                        end
                        OP_BSA: if (done) begin
                            ar_d = ar_q + ADDR_W'(1);
                            sc_d = T5;
                        end
                        default: sc_d = T0;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_BSA: begin
                            pc_d = ar_q;
                            sc_d = T0;
                        end
                        OP_ISZ: begin
                            dr_d = dr_q + DATA_W'(1);
                            sc_d = T6;
                        end
                        default: sc_d = T0;
                    endcase
                end
                T6: begin
                    if (opcode != OP_ISZ) begin
                        sc_d = T0;
                    end else if (done) begin
                        if (dr_q == '0) pc_d = pc_q + ADDR_W'(1);
                        sc_d = T0;
                    end
                end
                default: sc_d = T0;
            endcase
        end
    end

    // Architectural state register with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q     <= RESET_PC;
            ar_q     <= '0;
            ac_q     <= '0;
            dr_q     <= '0;
            ir_q     <= '0;
            e_q      <= 1'b0;
            ind_q    <= 1'b0;
            halted_q <= 1'b0;
            sc_q     <= T0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            pc_q     <= pc_d;
            ar_q     <= ar_d;
            ac_q     <= ac_d;
            dr_q     <= dr_d;
            ir_q     <= ir_d;
            e_q      <= e_d;
            ind_q    <= ind_d;
            halted_q <= halted_d;
            sc_q     <= sc_d;
        end
    end

    assign mem_addr = ar_q;
    assign halted   = halted_q;
    assign PC       = pc_q;
    assign AR       = ar_q;
    assign AC       = ac_q;
    assign DR       = dr_q;
    assign IR       = ir_q;
    assign E        = e_q;
    assign SC       = sc_q;

endmodule
